// File: rtl/color_select.sv
// Push-button color selector: per-button 2-FF synchronizer and debouncer feeding a
// priority-resolved, latched color selection with RGB, one-hot and change-pulse outputs.
module color_select #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter logic [2:0]  RESET_COLOR     = 3'b111
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Black,
   input  logic       Blue,
   input  logic       Green,
   input  logic       Cyan,
   input  logic       Red,
   input  logic       Magenta,
   input  logic       Yellow,
   input  logic       White,
   output logic [2:0] color_rgb,
   output logic [7:0] color_onehot,
   output logic       color_changed
);

   localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   // Bit index equals the button's RGB code.
   logic [7:0]    btn_s;
   logic [7:0]    sync1_q;
   logic [7:0]    sync2_q;
   logic [7:0]    db_q;
   logic [7:0]    db_d;
   logic [7:0]    db_prev_q;
   logic [CW-1:0] cnt_q [8];
   logic [CW-1:0] cnt_d [8];
   logic [7:0]    press_s;
   logic [2:0]    color_rgb_q;
   logic [2:0]    color_rgb_d;
   logic [7:0]    color_onehot_q;
   logic [7:0]    color_onehot_d;
   logic          color_changed_q;
   logic          color_changed_d;

   assign btn_s = {White, Yellow, Magenta, Red, Cyan, Green, Blue, Black};

   // Per-button debounce counters and accepted levels.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = cnt_q[i];
         db_d[i]  = db_q[i];
         if (sync2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            db_d[i]  = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   // Press events resolve by ascending scan, so the highest code wins.
   always_comb begin
      press_s         = db_q & ~db_prev_q;
      color_rgb_d     = color_rgb_q;
      color_changed_d = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (press_s[i]) begin
            color_rgb_d = 3'(i);
         end else begin
            color_rgb_d = color_rgb_d;
         end
      end
      if (|press_s) begin
         color_changed_d = (color_rgb_d != color_rgb_q);
      end else begin
         color_changed_d = 1'b0;
      end
      color_onehot_d = 8'd1 << color_rgb_d;
   end

   // State registers; reset also drops any event pending for the next edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q         <= 8'h00;
         sync2_q         <= 8'h00;
         db_q            <= 8'h00;
         db_prev_q       <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= '0;
         end
         color_rgb_q     <= RESET_COLOR;
         color_onehot_q  <= 8'd1 << RESET_COLOR;
         color_changed_q <= 1'b0;
      end else begin
         sync1_q         <= btn_s;
         sync2_q         <= sync1_q;
         db_q            <= db_d;
         db_prev_q       <= db_q;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         color_rgb_q     <= color_rgb_d;
         color_onehot_q  <= color_onehot_d;
         color_changed_q <= color_changed_d;
      end
   end

   assign color_rgb     = color_rgb_q;
   assign color_onehot  = color_onehot_q;
   assign color_changed = color_changed_q;

endmodule

// File: tb/tb_color_select.sv
// Directed, table-driven bench for color_select with DEBOUNCE_CYCLES=4.
module tb_color_select;

   typedef struct {
      logic       rst;
      logic [7:0] btn;
      int         cycles;
      logic [2:0] rgb;
      logic [7:0] oh;
      logic       chg;
      string      name;
   } vec_t;

   logic       clk;
   logic       reset;
   logic [7:0] btn;
   logic [2:0] color_rgb;
   logic [7:0] color_onehot;
   logic       color_changed;

   int   n_vec;
   int   n_miss;
   vec_t tbl[$];

   color_select #(
      .DEBOUNCE_CYCLES(4),
      .RESET_COLOR    (3'b111)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .Black        (btn[0]),
      .Blue         (btn[1]),
      .Green        (btn[2]),
      .Cyan         (btn[3]),
      .Red          (btn[4]),
      .Magenta      (btn[5]),
      .Yellow       (btn[6]),
      .White        (btn[7]),
      .color_rgb    (color_rgb),
      .color_onehot (color_onehot),
      .color_changed(color_changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [7:0] b, input int c,
                      input logic [2:0] rgb, input logic [7:0] oh, input logic chg,
                      input string nm);
      vec_t v;
      v.rst = r; v.btn = b; v.cycles = c; v.rgb = rgb; v.oh = oh; v.chg = chg; v.name = nm;
      tbl.push_back(v);
   endtask

   task automatic check(input string nm, input logic [2:0] rgb, input logic [7:0] oh,
                        input logic chg);
      n_vec++;
      if (color_rgb !== rgb || color_onehot !== oh || color_changed !== chg) begin
         n_miss++;
         $display("FAIL %s: got rgb=%b onehot=%h changed=%b, expected rgb=%b onehot=%h changed=%b",
                  nm, color_rgb, color_onehot, color_changed, rgb, oh, chg);
      end
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      reset  = 1'b1;
      btn    = 8'h00;

      // Inputs change 1 time unit after a rising edge, so a new level is first
      // sampled on the next edge; a held press selects 7 edges after it is driven.
      // Blue glitches (3 high, 2 low, 3 high) never reach DEBOUNCE_CYCLES.
      add(0, 8'h02, 3, 3'b111, 8'h80, 0, "blue_glitch_a");
      add(0, 8'h00, 2, 3'b111, 8'h80, 0, "blue_glitch_gap");
      add(0, 8'h02, 3, 3'b111, 8'h80, 0, "blue_glitch_b");
      add(0, 8'h00, 8, 3'b111, 8'h80, 0, "blue_glitch_idle");
      add(0, 8'h02, 6, 3'b111, 8'h80, 0, "blue_pre");
      add(0, 8'h02, 1, 3'b001, 8'h02, 1, "blue_sel");
      add(0, 8'h02, 1, 3'b001, 8'h02, 0, "blue_pulse_end");
      add(0, 8'h00, 8, 3'b001, 8'h02, 0, "blue_release");
      // Red held: one pulse only
      add(0, 8'h10, 6, 3'b001, 8'h02, 0, "red_pre");
      add(0, 8'h10, 1, 3'b100, 8'h10, 1, "red_sel");
      add(0, 8'h10, 1, 3'b100, 8'h10, 0, "red_pulse_end");
      add(0, 8'h10, 10, 3'b100, 8'h10, 0, "red_hold");
      add(0, 8'h00, 8, 3'b100, 8'h10, 0, "red_release");
      // Green + Magenta on the same edge: Magenta wins
      add(0, 8'h24, 6, 3'b100, 8'h10, 0, "gm_pre");
      add(0, 8'h24, 1, 3'b101, 8'h20, 1, "gm_sel");
      add(0, 8'h24, 1, 3'b101, 8'h20, 0, "gm_pulse_end");
      add(0, 8'h00, 8, 3'b101, 8'h20, 0, "gm_release");
      // White, then White again (no change pulse), then Black
      add(0, 8'h80, 6, 3'b101, 8'h20, 0, "white_pre");
      add(0, 8'h80, 1, 3'b111, 8'h80, 1, "white_sel");
      add(0, 8'h80, 1, 3'b111, 8'h80, 0, "white_pulse_end");
      add(0, 8'h00, 8, 3'b111, 8'h80, 0, "white_release");
      add(0, 8'h80, 7, 3'b111, 8'h80, 0, "white_again");
      add(0, 8'h80, 1, 3'b111, 8'h80, 0, "white_again_quiet");
      add(0, 8'h00, 8, 3'b111, 8'h80, 0, "white_again_release");
      add(0, 8'h01, 6, 3'b111, 8'h80, 0, "black_pre");
      add(0, 8'h01, 1, 3'b000, 8'h01, 1, "black_sel");
      add(0, 8'h01, 1, 3'b000, 8'h01, 0, "black_pulse_end");
      // Yellow pressed while Black still held
      add(0, 8'h41, 6, 3'b000, 8'h01, 0, "yellow_pre");
      add(0, 8'h41, 1, 3'b110, 8'h40, 1, "yellow_sel");
      add(0, 8'h41, 1, 3'b110, 8'h40, 0, "yellow_pulse_end");
      add(0, 8'h00, 8, 3'b110, 8'h40, 0, "by_release");
      // Cyan, then Red two cycles later: applied in order, last wins
      add(0, 8'h08, 2, 3'b110, 8'h40, 0, "order_cyan");
      add(0, 8'h18, 4, 3'b110, 8'h40, 0, "order_pre");
      add(0, 8'h18, 1, 3'b011, 8'h08, 1, "order_cyan_sel");
      add(0, 8'h18, 1, 3'b011, 8'h08, 0, "order_cyan_end");
      add(0, 8'h18, 1, 3'b100, 8'h10, 1, "order_red_sel");
      add(0, 8'h18, 1, 3'b100, 8'h10, 0, "order_red_end");
      add(0, 8'h00, 8, 3'b100, 8'h10, 0, "order_release");
      // Cyan held; reset lands on the edge where db would rise
      add(0, 8'h08, 5, 3'b100, 8'h10, 0, "cyan_pre_reset");
      add(1, 8'h08, 1, 3'b111, 8'h80, 0, "cyan_reset_hit");
      add(1, 8'h08, 2, 3'b111, 8'h80, 0, "cyan_in_reset");
      add(0, 8'h08, 6, 3'b111, 8'h80, 0, "cyan_post_reset_pre");
      add(0, 8'h08, 1, 3'b011, 8'h08, 1, "cyan_post_reset_sel");
      add(0, 8'h08, 1, 3'b011, 8'h08, 0, "cyan_post_reset_end");

      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 3'b111, 8'h80, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         check("idle_stable", 3'b111, 8'h80, 1'b0);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         reset = tbl[i].rst;
         btn   = tbl[i].btn;
         repeat (tbl[i].cycles) @(posedge clk);
         #1;
         check(tbl[i].name, tbl[i].rgb, tbl[i].oh, tbl[i].chg);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
